rr_arb_32: RTL and testbench
============================

Name: rr_arb_32

Overview:
- 32-port round-robin arbiter. It produces the registered one-hot grant vector that the 32-way one-hot select mux consumes as its `state` input.
- It sits in front of each shared resource, for example a shared SRAM write port or an output queue, and serialises requests from 32 ingress ports.
- A grant is held (locked) until the owner signals release. Fairness is enforced by a rotating search pointer.

Parameters:
- PORT_NUM, 32, number of requesters. Fixed at 32 for this block.
- IDX_WIDTH, 5, width of the binary grant index.
- MAX_HOLD, 64, maximum cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  32  per-port request level; bit i = port i.
- rel  input  1  release strobe from the current owner; sampled only in GRANT.
- gnt  output  32  registered one-hot grant; all-zero when idle. Connects directly to the mux `state` input.
- gnt_vld  output  1  registered; high iff gnt != 0.
- gnt_idx  output  5  registered binary index of the granted port; 0 when idle.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked. Present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync-style deassert use):
  - gnt=0, gnt_vld=0, gnt_idx=0, timeout=0.
  - Search pointer ptr=0, hold counter=0, state=IDLE.
- States: IDLE and GRANT.
- Pick function (combinational): the first set bit of req scanning circularly from ptr upward (ptr, ptr+1, ..., 31, 0, ..., ptr-1).
- IDLE:
  - If req != 0: at the next edge, gnt = onehot(pick), gnt_idx = pick, gnt_vld = 1, and state goes to GRANT. Latency is 1 cycle from req to gnt.
  - If req == 0: remain in IDLE; outputs stay 0.
  - rel in IDLE is ignored.
- GRANT:
  - gnt, gnt_idx and gnt_vld are held stable. Changes on req, including the owner dropping its own req, are ignored until release.
  - On rel=1: ptr ← gnt_idx+1 (mod 32, so 31 wraps to 0). The next owner is picked in the same cycle using the new ptr.
    - If any req is set, the new grant is registered at that edge (no idle bubble) and state stays GRANT.
    - If req == 0, outputs clear to 0 at that edge and state goes to IDLE.
  - The releasing port is eligible again but has the lowest priority. If it is the sole requester, it is re-granted immediately.
- Invariant: gnt is always all-zero or exactly one-hot. gnt_idx is always consistent with gnt.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously) and ptr returns to 0.
- The hold counter counts cycles in GRANT. It resets to 0 on every new grant and on entry to IDLE.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - When the hold counter reaches MAX_HOLD-1 and rel=0, the arbiter behaves exactly as if rel=1 on that cycle.
  - timeout pulses high for one cycle, aligned with the edge at which the grant changes.
  - If rel=1 and the timeout both occur in the same cycle, it is treated as a normal release and timeout stays 0.
- ARB_TIMEOUT_EN undefined:
  - No hold counter and no timeout port.
  - A grant is held indefinitely until rel.

Decomposition:
- Shared package arb_pkg:
  - localparams PORT_NUM=32, IDX_WIDTH=5.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - typedef logic [31:0] port_vec_t, shared with the mux-side consumers.
- One natural sub-module: rr_pick_32. It is purely combinational: inputs req and ptr, outputs pick_vld and pick_idx. Implement it with a double-width masked priority encode.
- The registered state machine and the pointer/counter logic stay in rr_arb_32.

Test Plan:
- Reset with req=32'hFFFF_FFFF held → outputs 0 during reset. First edge after reset → gnt=32'h0000_0001, gnt_idx=0.
- Rotation: req=32'h8000_0011 held, rel pulsed every 3 cycles → grant sequence idx 0, 4, 31, 0. Each new grant appears at the same edge that samples rel, with no bubble.
- Single requester: req=32'h0000_0400, rel pulsed → idx 10 re-granted back-to-back; gnt never drops to 0.
- Lock: grant on idx 5, then req[5] dropped and req[6] raised with rel=0 for 10 cycles → gnt stays 32'h0000_0020. rel=1 → gnt=32'h0000_0040.
- Idle return and pointer: grant idx 31, req=0, rel=1 → gnt=0, gnt_vld=0. Then req=32'h0000_0003 → idx 0 (ptr wrapped).
- With ARB_TIMEOUT_EN and MAX_HOLD=8: req=32'h0000_0006, no rel → idx 1 revoked after 8 cycles in GRANT, timeout pulses once, idx 2 granted. An async reset mid-hold → immediate clear, and no timeout pulse.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 32-port round-robin arbiter and its mux-side consumers.
package arb_pkg;

    localparam int unsigned PORT_NUM  = 32;
    localparam int unsigned IDX_WIDTH = 5;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [PORT_NUM-1:0] port_vec_t;

endpackage

// File: rtl/rr_pick_32.sv
// Combinational circular first-set search of req starting at ptr.
module rr_pick_32
    import arb_pkg::*;
(
    input  port_vec_t              req,
    input  logic [IDX_WIDTH-1:0]   ptr,
    output logic                   pick_vld,
    output logic [IDX_WIDTH-1:0]   pick_idx
);

    port_vec_t                 mask_hi;
    logic [2*PORT_NUM-1:0]     dbl;

    // Upper copy is unmasked so the search wraps below ptr when nothing at or above ptr is set.
    always_comb begin
        mask_hi  = ~((port_vec_t'(1) << ptr) - port_vec_t'(1));
        dbl      = {req, req & mask_hi};
        pick_vld = |req;
        pick_idx = '0;
        for (int i = int'(2 * PORT_NUM) - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pick_idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arb_32.sv
// 32-port locking round-robin arbiter with registered one-hot grant.
// Optional forced revocation of long-held grants with `define ARB_TIMEOUT_EN.
module rr_arb_32
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = 64
)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    input  port_vec_t              req,
    input  logic                   rel,
    output port_vec_t              gnt,
    output logic                   gnt_vld,
    output logic [IDX_WIDTH-1:0]   gnt_idx
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);

    arb_state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0]     ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]     pick_ptr;
    logic                     rel_eff;
    logic                     pick_vld;
    logic [IDX_WIDTH-1:0]     pick_idx;
    port_vec_t                gnt_d;
    logic                     gnt_vld_d;
    logic [IDX_WIDTH-1:0]     gnt_idx_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     expire;
    logic                     timeout_d;

    // An expiring hold acts as a release; a genuine rel in the same cycle suppresses the pulse.
    always_comb begin
        expire    = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));
        rel_eff   = rel | expire;
        timeout_d = expire & ~rel;
        hold_d    = ((state_q == GRANT) && !rel_eff) ? hold_q + HOLD_W'(1) : '0;
    end
`else
    assign rel_eff = rel;
`endif

    // On release the search starts just past the owner, so the new owner is picked this cycle.
    assign pick_ptr = ((state_q == GRANT) && rel_eff) ? gnt_idx + IDX_WIDTH'(1) : ptr_q;

    rr_pick_32 u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt;
        gnt_vld_d = gnt_vld;
        gnt_idx_d = gnt_idx;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d   = GRANT;
                    gnt_d     = port_vec_t'(1) << pick_idx;
                    gnt_vld_d = 1'b1;
                    gnt_idx_d = pick_idx;
                end
            end
            GRANT: begin
                if (rel_eff) begin
                    ptr_d = pick_ptr;
                    if (pick_vld) begin
                        gnt_d     = port_vec_t'(1) << pick_idx;
                        gnt_vld_d = 1'b1;
                        gnt_idx_d = pick_idx;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_vld_d = 1'b0;
                        gnt_idx_d = '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                gnt_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            gnt_vld <= gnt_vld_d;
            gnt_idx <= gnt_idx_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            timeout <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            timeout <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb_32.sv
// Directed self-checking bench for rr_arb_32; timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_rr_arb_32;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        rel;
    logic [31:0] gnt;
    logic        gnt_vld;
    logic [4:0]  gnt_idx;
`ifdef ARB_TIMEOUT_EN
    logic        timeout;
`endif

    int n_cmp;
    int n_fail;

`ifdef ARB_TIMEOUT_EN
    rr_arb_32 #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .timeout (timeout)
    );
`else
    rr_arb_32 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 32'hFFFF_FFFF;
        rel = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_gnt: got %h want %h", gnt, 32'h0);
        end
        n_cmp++;
        if (gnt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vld: got %b want 0", gnt_vld);
        end
        n_cmp++;
        if (gnt_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_idx: got %0d want 0", gnt_idx);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 32'h0000_0001 || gnt_idx !== 5'd0 || gnt_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got gnt=%h idx=%0d vld=%b want gnt=00000001 idx=0 vld=1",
                     gnt, gnt_idx, gnt_vld);
        end
    endtask

    task automatic test_rotation();
        logic [4:0] exp_seq [4];
        logic [31:0] exp_gnt;
        exp_seq[0] = 5'd0;
        exp_seq[1] = 5'd4;
        exp_seq[2] = 5'd31;
        exp_seq[3] = 5'd0;
        do_reset();
        req = 32'h8000_0011;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_gnt = 32'h1 << exp_seq[k];
            n_cmp++;
            if (gnt_idx !== exp_seq[k] || gnt !== exp_gnt || gnt_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation_%0d: got idx=%0d gnt=%h want idx=%0d gnt=%h",
                         k, gnt_idx, gnt, exp_seq[k], exp_gnt);
            end
            if (k < 3) begin
                tick();
                n_cmp++;
                if (gnt !== exp_gnt) begin
                    n_fail++;
                    $display("FAIL rotation_hold_%0d: got %h want %h", k, gnt, exp_gnt);
                end
                tick();
                rel = 1'b1;
                tick();
                rel = 1'b0;
            end
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        req = 32'h0000_0400;
        tick();
        rel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (gnt !== 32'h0000_0400 || gnt_idx !== 5'd10) begin
                n_fail++;
                $display("FAIL single_regrant_%0d: got gnt=%h idx=%0d want gnt=00000400 idx=10",
                         k, gnt, gnt_idx);
            end
            tick();
        end
        rel = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        req = 32'h0000_0020;
        tick();
        req = 32'h0000_0040;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (gnt !== 32'h0000_0020 || gnt_idx !== 5'd5) begin
                n_fail++;
                $display("FAIL lock_%0d: got gnt=%h idx=%0d want gnt=00000020 idx=5",
                         k, gnt, gnt_idx);
            end
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        n_cmp++;
        if (gnt !== 32'h0000_0040 || gnt_idx !== 5'd6) begin
            n_fail++;
            $display("FAIL lock_release: got gnt=%h idx=%0d want gnt=00000040 idx=6", gnt, gnt_idx);
        end
    endtask

    task automatic test_idle_pointer();
        do_reset();
        req = 32'h8000_0000;
        tick();
        n_cmp++;
        if (gnt_idx !== 5'd31) begin
            n_fail++;
            $display("FAIL idle_grant31: got idx=%0d want 31", gnt_idx);
        end
        req = '0;
        rel = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 32'h0 || gnt_vld !== 1'b0 || gnt_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_clear: got gnt=%h vld=%b idx=%0d want 0/0/0", gnt, gnt_vld, gnt_idx);
        end
        tick();
        n_cmp++;
        if (gnt !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_rel_ignored: got %h want 0", gnt);
        end
        rel = 1'b0;
        req = 32'h0000_0003;
        tick();
        n_cmp++;
        if (gnt !== 32'h0000_0001 || gnt_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL ptr_wrap: got gnt=%h idx=%0d want gnt=00000001 idx=0", gnt, gnt_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 32'h0000_0100;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 32'h0 || gnt_vld !== 1'b0 || gnt_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%h vld=%b idx=%0d want 0/0/0", gnt, gnt_vld, gnt_idx);
        end
        tick();
        rst = 1'b0;
        req = 32'h0000_0101;
        tick();
        n_cmp++;
        if (gnt_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset_ptr: got idx=%0d want 0", gnt_idx);
        end
        req = '0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        do_reset();
        req = 32'h0000_0006;
        tick();
        pulses = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (timeout === 1'b1) pulses++;
            n_cmp++;
            if (gnt_idx !== 5'd1) begin
                n_fail++;
                $display("FAIL timeout_hold_%0d: got idx=%0d want 1", k, gnt_idx);
            end
        end
        tick();
        n_cmp++;
        if (gnt_idx !== 5'd2 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_revoke: got idx=%0d timeout=%b want idx=2 timeout=1", gnt_idx, timeout);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || pulses != 0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got timeout=%b early=%0d want 0/0", timeout, pulses);
        end
        for (int k = 0; k < 3; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 32'h0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_reset: got gnt=%h timeout=%b want 0/0", gnt, timeout);
        end
        tick();
        rst = 1'b0;
        req = '0;
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        test_reset();
        test_rotation();
        test_single_requester();
        test_lock();
        test_idle_pointer();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
